// File: rtl/dmem_mmio_ctrl.sv
// Data RAM plus memory-mapped peripheral controller with a registered response path.
// Optional fault logging is built only when DMEM_FAULT_LOG_EN is defined.
module dmem_mmio_ctrl #(
    parameter int DMEM_DEPTH     = 256,
    parameter int NUM_PERIPH     = 2,
    parameter int PERIPH_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [2:0]              op_sel,
    input  logic [31:0]             addr,
    input  logic [31:0]             data_w,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [31:0]             data_r,
    output logic [NUM_PERIPH-1:0]   p_sel,
    output logic                    p_we,
    output logic [31:0]             p_addr,
    output logic [31:0]             p_wdata,
    input  logic [32*NUM_PERIPH-1:0] p_rdata,
    input  logic [NUM_PERIPH-1:0]   p_ack,
    output logic [31:0]             fault_addr,
    output logic [7:0]              fault_cnt
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PWAIT = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic                    rsp_valid_r, rsp_valid_s;
    logic                    rsp_err_r, rsp_err_s;
    logic [31:0]             rdata_r, rdata_s;
    logic [NUM_PERIPH-1:0]   p_sel_r, p_sel_s;
    logic                    p_we_r, p_we_s;
    logic [31:0]             p_addr_r, p_addr_s;
    logic [31:0]             p_wdata_r, p_wdata_s;
    logic [2:0]              op_r, op_s;
    logic [7:0]              cnt_r, cnt_s;

    logic                    one_en_s, op_ok_s, align_ok_s;
    logic                    is_ram_s, is_per_s, req_ok_s;
    logic [3:0]              be_s;
    logic [31:0]             wdata_s;
    logic                    ram_we_s;
    logic [AW-1:0]           ram_idx_s;
    logic [31:0]             ram_word_s;
    logic                    ack_s;
    logic [31:0]             prdata_s;

    logic [31:0] mem_r [DMEM_DEPTH] = '{default: 32'h0};

    // Selects the addressed lane(s) of a word and sign/zero-extends per funct3
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  op);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (op)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b010:  load_ext = sh;
            3'b100:  load_ext = {24'h000000, sh[7:0]};
            3'b101:  load_ext = {16'h0000, sh[15:0]};
            default: load_ext = 32'h00000000;
        endcase
    endfunction

    assign ram_idx_s  = addr[AW+1:2];
    assign ram_word_s = mem_r[ram_idx_s];
    assign ack_s      = |(p_ack & p_sel_r);

    // Request legality: enables, funct3 per direction, alignment and address region
    always_comb begin
        one_en_s = w_en ^ r_en;
        case (op_sel)
            3'b000, 3'b001, 3'b010: op_ok_s = 1'b1;
            3'b100, 3'b101:         op_ok_s = r_en;
            default:                op_ok_s = 1'b0;
        endcase
        case (op_sel[1:0])
            2'b01:   align_ok_s = (addr[0] == 1'b0);
            2'b10:   align_ok_s = (addr[1:0] == 2'b00);
            default: align_ok_s = 1'b1;
        endcase
        is_ram_s = (addr[31:28] == 4'h0) && ({2'b00, addr[31:2]} < 32'(DMEM_DEPTH));
        is_per_s = (addr[31:28] == 4'h4) && ({28'h0000000, addr[27:24]} < 32'(NUM_PERIPH));
        req_ok_s = one_en_s && op_ok_s && align_ok_s && (is_ram_s || is_per_s);
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = data_w;
        case (op_sel[1:0])
            2'b00: begin
                be_s    = 4'b0001 << addr[1:0];
                wdata_s = {4{data_w[7:0]}};
            end
            2'b01: begin
                be_s    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{data_w[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = data_w;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = data_w;
            end
        endcase
    end

    // Read data of the selected peripheral channel
    always_comb begin
        prdata_s = 32'h00000000;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            if (p_sel_r[k]) begin
                prdata_s = prdata_s | p_rdata[32*k +: 32];
            end else begin
                prdata_s = prdata_s;
            end
        end
    end

    // Next-state and next-output logic of the IDLE/PWAIT controller
    always_comb begin
        state_s     = state_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rdata_s     = 32'h00000000;
        p_sel_s     = p_sel_r;
        p_we_s      = p_we_r;
        p_addr_s    = p_addr_r;
        p_wdata_s   = p_wdata_r;
        op_s        = op_r;
        cnt_s       = cnt_r;
        ram_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A request with neither enable is consumed silently
                if (req_valid && (w_en || r_en)) begin
                    if (!req_ok_s) begin
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                    end else if (is_ram_s) begin
                        rsp_valid_s = 1'b1;
                        if (w_en) begin
                            ram_we_s = 1'b1;
                        end else begin
                            rdata_s = load_ext(ram_word_s, addr[1:0], op_sel);
                        end
                    end else begin
                        state_s   = ST_PWAIT;
                        p_sel_s   = NUM_PERIPH'(1'b1) << addr[27:24];
                        p_we_s    = w_en;
                        p_addr_s  = addr;
                        p_wdata_s = w_en ? data_w : 32'h00000000;
                        op_s      = op_sel;
                        cnt_s     = 8'h00;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PWAIT: begin
                // Ack is checked first so it wins over a simultaneous timeout
                if (ack_s) begin
                    rsp_valid_s = 1'b1;
                    rdata_s     = p_we_r ? 32'h00000000 : load_ext(prdata_s, 2'b00, op_r);
                    p_sel_s     = '0;
                    state_s     = ST_IDLE;
                end else if (cnt_r == 8'(PERIPH_TIMEOUT - 1)) begin
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    p_sel_s     = '0;
                    state_s     = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'h01;
                end
            end
            default: begin
                state_s = ST_IDLE;
                p_sel_s = '0;
            end
        endcase
    end

    // Controller state and registered bus outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rdata_r     <= 32'h00000000;
            p_sel_r     <= '0;
            p_we_r      <= 1'b0;
            p_addr_r    <= 32'h00000000;
            p_wdata_r   <= 32'h00000000;
            op_r        <= 3'b000;
            cnt_r       <= 8'h00;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rdata_r     <= rdata_s;
            p_sel_r     <= p_sel_s;
            p_we_r      <= p_we_s;
            p_addr_r    <= p_addr_s;
            p_wdata_r   <= p_wdata_s;
            op_r        <= op_s;
            cnt_r       <= cnt_s;
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[ram_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_FAULT_LOG_EN
    logic        fault_s;
    logic [31:0] fault_addr_s;
    logic [31:0] fault_addr_r;
    logic [7:0]  fault_cnt_r;

    // Faults come from decode in IDLE or from a peripheral timeout in PWAIT
    always_comb begin
        fault_s      = rsp_valid_s && rsp_err_s;
        fault_addr_s = (state_r == ST_PWAIT) ? p_addr_r : addr;
    end

    // Fault address capture and saturating fault counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_addr_r <= 32'h00000000;
            fault_cnt_r  <= 8'h00;
        end else if (fault_s) begin
            fault_addr_r <= fault_addr_s;
            fault_cnt_r  <= (fault_cnt_r == 8'hFF) ? 8'hFF : fault_cnt_r + 8'h01;
        end
    end

    assign fault_addr = fault_addr_r;
    assign fault_cnt  = fault_cnt_r;
`else
    assign fault_addr = 32'h00000000;
    assign fault_cnt  = 8'h00;
`endif

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign data_r    = rdata_r;
    assign p_sel     = p_sel_r;
    assign p_we      = p_we_r;
    assign p_addr    = p_addr_r;
    assign p_wdata   = p_wdata_r;

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed bench for dmem_mmio_ctrl: scoreboard of expected responses checked at each rsp_valid.
module tb_dmem_mmio_ctrl;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
`ifdef DMEM_FAULT_LOG_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, w_en, r_en;
    logic [2:0]  op_sel;
    logic [31:0] addr, data_w;
    logic        rsp_valid, rsp_err;
    logic [31:0] data_r;
    logic [1:0]  p_sel;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    logic [63:0] p_rdata;
    logic [1:0]  p_ack;
    logic [31:0] fault_addr;
    logic [7:0]  fault_cnt;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    dmem_mmio_ctrl #(.DMEM_DEPTH(256), .NUM_PERIPH(2), .PERIPH_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .w_en(w_en), .r_en(r_en), .op_sel(op_sel), .addr(addr), .data_w(data_w),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .data_r(data_r),
        .p_sel(p_sel), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack), .fault_addr(fault_addr), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation, including its cycle
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_rsp observed=err%b/%h expected=none at cyc %0d", rsp_err, data_r, cyc);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
                chk("rsp_data", data_r, mon_e.data);
            end
        end
    end

    task automatic issue(input logic we, input logic re, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd, input bit rsp,
                         input logic err, input logic [31:0] exp_d, input int lat);
        req_valid = 1'b1; w_en = we; r_en = re; op_sel = op; addr = a; data_w = wd;
        chk("req_ready_at_issue", {31'h0, req_ready}, 32'h1);
        if (rsp) sb.push_back('{err, exp_d, cyc + lat});
        @(posedge clk); #1;
        req_valid = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic periph(input int ncyc, input int ack_at, input logic [1:0] sel_exp,
                          input logic [63:0] rd, input logic we_exp, input logic [31:0] a_exp);
        p_rdata = rd;
        for (int i = 1; i <= ncyc; i++) begin
            chk("pwait_ready", {31'h0, req_ready}, 32'h0);
            chk("pwait_sel", {30'h0, p_sel}, {30'h0, sel_exp});
            chk("pwait_we", {31'h0, p_we}, {31'h0, we_exp});
            chk("pwait_addr", p_addr, a_exp);
            p_ack = (i == ack_at) ? sel_exp : ~sel_exp;
            @(posedge clk); #1;
            p_ack = 2'b00;
        end
        chk("post_sel", {30'h0, p_sel}, 32'h0);
        chk("post_ready", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; w_en = 1'b0; r_en = 1'b0; op_sel = 3'b000;
        addr = 32'h0; data_w = 32'h0; p_ack = 2'b00; p_rdata = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_data_r", data_r, 32'h0);
        chk("rst_p_sel", {30'h0, p_sel}, 32'h0);
        chk("rst_p_we", {31'h0, p_we}, 32'h0);
        chk("rst_p_addr", p_addr, 32'h0);
        chk("rst_p_wdata", p_wdata, 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_fault_cnt", {24'h0, fault_cnt}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // RAM word/byte, back-to-back
        issue(1'b1, 1'b0, OP_W,  32'h10, 32'hA5B6C7D8, 1'b1, 1'b0, 32'h0,        1);
        issue(1'b0, 1'b1, OP_W,  32'h10, 32'h0,        1'b1, 1'b0, 32'hA5B6C7D8, 1);
        issue(1'b0, 1'b1, OP_B,  32'h13, 32'h0,        1'b1, 1'b0, 32'hFFFFFFA5, 1);
        issue(1'b1, 1'b0, OP_B,  32'h11, 32'h0000005A, 1'b1, 1'b0, 32'h0,        1);
        issue(1'b0, 1'b1, OP_W,  32'h10, 32'h0,        1'b1, 1'b0, 32'hA5B65AD8, 1);
        issue(1'b0, 1'b1, OP_BU, 32'h13, 32'h0,        1'b1, 1'b0, 32'h000000A5, 1);
        issue(1'b0, 1'b0, OP_W,  32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        0);
        // Halfwords and a misaligned word
        issue(1'b1, 1'b0, OP_H,  32'h22, 32'h00008001, 1'b1, 1'b0, 32'h0,        1);
        issue(1'b0, 1'b1, OP_HU, 32'h22, 32'h0,        1'b1, 1'b0, 32'h00008001, 1);
        issue(1'b0, 1'b1, OP_H,  32'h22, 32'h0,        1'b1, 1'b0, 32'hFFFF8001, 1);
        issue(1'b0, 1'b1, OP_W,  32'h22, 32'h0,        1'b1, 1'b1, 32'h0,        1);
        chk("fault_addr_misalign", fault_addr, FL ? 32'h22 : 32'h0);
        chk("fault_cnt_1", {24'h0, fault_cnt}, FL ? 32'd1 : 32'd0);

        // Peripheral read on channel 1, ack on 3rd PWAIT cycle
        issue(1'b0, 1'b1, OP_W, 32'h41000004, 32'h0, 1'b1, 1'b0, 32'h00001234, 4);
        periph(3, 3, 2'b10, {32'h00001234, 32'hDEADBEEF}, 1'b0, 32'h41000004);
        p_ack = 2'b11;
        @(posedge clk); #1;
        p_ack = 2'b00;
        chk("idle_ack_ready", {31'h0, req_ready}, 32'h1);

        // Peripheral write on channel 0, minimum latency
        issue(1'b1, 1'b0, OP_W, 32'h40000008, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 2);
        chk("p_wdata", p_wdata, 32'hCAFEF00D);
        periph(1, 1, 2'b01, {32'h11111111, 32'h22222222}, 1'b1, 32'h40000008);

        // Timeout on channel 0, then ack exactly on the last allowed PWAIT cycle
        issue(1'b0, 1'b1, OP_W, 32'h40000000, 32'h0, 1'b1, 1'b1, 32'h0, 16);
        periph(15, 0, 2'b01, {32'h33333333, 32'h44444444}, 1'b0, 32'h40000000);
        chk("fault_addr_timeout", fault_addr, FL ? 32'h40000000 : 32'h0);
        chk("fault_cnt_2", {24'h0, fault_cnt}, FL ? 32'd2 : 32'd0);
        issue(1'b0, 1'b1, OP_W, 32'h40000010, 32'h0, 1'b1, 1'b0, 32'h00000ABC, 16);
        periph(15, 15, 2'b01, {32'h55555555, 32'h00000ABC}, 1'b0, 32'h40000010);
        chk("fault_cnt_still_2", {24'h0, fault_cnt}, FL ? 32'd2 : 32'd0);

        // Decode errors
        issue(1'b0, 1'b1, OP_W,  32'h80000000, 32'h0,        1'b1, 1'b1, 32'h0, 1);
        issue(1'b0, 1'b1, OP_W,  32'h45000000, 32'h0,        1'b1, 1'b1, 32'h0, 1);
        issue(1'b0, 1'b1, OP_W,  32'h00000400, 32'h0,        1'b1, 1'b1, 32'h0, 1);
        issue(1'b1, 1'b1, OP_W,  32'h00000010, 32'h0,        1'b1, 1'b1, 32'h0, 1);
        issue(1'b1, 1'b0, OP_BU, 32'h00000010, 32'h0,        1'b1, 1'b1, 32'h0, 1);
        issue(1'b1, 1'b0, OP_W,  32'h00000012, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 1);
        issue(1'b0, 1'b1, OP_W,  32'h00000010, 32'h0,        1'b1, 1'b0, 32'hA5B65AD8, 1);
        chk("fault_addr_store", fault_addr, FL ? 32'h12 : 32'h0);
        chk("fault_cnt_8", {24'h0, fault_cnt}, FL ? 32'd8 : 32'd0);

        // Saturation of the fault counter
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, 1'b1, OP_W, 32'h90000000 | 32'(i * 4), 32'h0, 1'b1, 1'b1, 32'h0, 1);
        end
        chk("fault_cnt_sat", {24'h0, fault_cnt}, FL ? 32'd255 : 32'd0);
        chk("fault_addr_last", fault_addr, FL ? 32'h900003FC : 32'h0);

        // Reset during PWAIT aborts the transaction
        issue(1'b0, 1'b1, OP_W, 32'h41000000, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        chk("abort_sel_before", {30'h0, p_sel}, 32'h2);
        #2 rst = 1'b0;
        #1;
        chk("abort_sel_now", {30'h0, p_sel}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_fault_cnt", {24'h0, fault_cnt}, 32'h0);
        p_ack = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        p_ack = 2'b00;

        // RAM contents survive reset
        issue(1'b0, 1'b1, OP_W, 32'h10, 32'h0, 1'b1, 1'b0, 32'hA5B65AD8, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
